// File: rtl/ahb_arbiter_if.sv
// Arbitration signal bundle between the AHB masters/muxes and the round-robin arbiter.
// master: request side (requests, muxed HTRANS/HREADY); slave: the arbiter itself.
interface ahb_arbiter_if #(
  parameter int MASTER_COUNT = 4,
  parameter int MASTER_IDX_W = 2
);
  logic [MASTER_COUNT-1:0] HBUSREQ;
  logic [MASTER_COUNT-1:0] HLOCK;
  logic [1:0]              HTRANS;
  logic                    HREADY;
  logic [MASTER_COUNT-1:0] HGRANT;
  logic [MASTER_IDX_W-1:0] HMASTER;
  logic                    HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: parks on DEFAULT_MASTER, honours HLOCK and bounds
// unlocked ownership with a MAX_HOLD transfer limit while other masters wait.
module ahb_arbiter #(
  parameter int MASTER_COUNT   = 4,
  parameter int MASTER_IDX_W   = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16,
  localparam int HOLD_W        = $clog2(MAX_HOLD + 1)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_arbiter_if.slave      bus,
  output logic              dbg_state_o,     // 0 = parked, 1 = a master owns the bus
  output logic [HOLD_W-1:0] dbg_hold_cnt_o
);

  // Handshake: every register update is qualified by HREADY=1 on the rising edge;
  // HREADY=0 freezes grant, HMASTER, HMASTLOCK, hold counter, pointer and state.

  typedef enum logic {ST_PARK = 1'b0, ST_OWN = 1'b1} state_t;

  localparam logic [MASTER_IDX_W-1:0] DEF_IDX  = MASTER_IDX_W'(DEFAULT_MASTER);
  localparam logic [HOLD_W-1:0]       HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [1:0]              HT_NONSEQ = 2'b10;
  localparam logic [1:0]              HT_SEQ    = 2'b11;

  state_t                  state_q, state_d;
  logic [MASTER_IDX_W-1:0] owner_q, owner_d;
  logic [MASTER_COUNT-1:0] grant_q, grant_d;
  logic [MASTER_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [MASTER_IDX_W-1:0] hmaster_q, hmaster_d;
  logic                    hmastlock_q, hmastlock_d;

  logic [MASTER_COUNT-1:0] others_req;
  logic [MASTER_COUNT-1:0] scan_req;
  logic                    owner_free;
  logic                    rel_a;
  logic                    rel_b;
  logic                    decide;
  logic                    beat;
  logic                    win_found;
  logic [MASTER_IDX_W-1:0] win_idx;
  int                      k;

  always_comb begin
    others_req = bus.HBUSREQ & ~(MASTER_COUNT'(1) << owner_q);
    owner_free = !bus.HLOCK[owner_q];
    rel_a      = (state_q == ST_OWN) && owner_free && !bus.HBUSREQ[owner_q];
    rel_b      = (state_q == ST_OWN) && owner_free && bus.HBUSREQ[owner_q] &&
                 (hold_cnt_q == HOLD_MAX) && (|others_req);
    decide     = ((state_q == ST_PARK) && (|bus.HBUSREQ)) || rel_a || rel_b;
    // A hold-limit handover must pass the bus on, so the owner is masked out.
    scan_req   = rel_b ? others_req : bus.HBUSREQ;
    beat       = ((bus.HTRANS == HT_NONSEQ) || (bus.HTRANS == HT_SEQ)) &&
                 (hmaster_q == owner_q);
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    k         = 0;
    for (int i = 1; i <= MASTER_COUNT; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= MASTER_COUNT) k = k - MASTER_COUNT;
      if (!win_found && scan_req[k]) begin
        win_found = 1'b1;
        win_idx   = MASTER_IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (decide) begin
      hold_cnt_d = '0;
      if (win_found) begin
        state_d  = ST_OWN;
        owner_d  = win_idx;
        rr_ptr_d = win_idx;
      end else begin
        state_d = ST_PARK;
        owner_d = DEF_IDX;
      end
    end else if (beat && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    grant_d     = MASTER_COUNT'(1) << owner_d;
    // Address phase follows the grant that was visible before this edge.
    hmaster_d   = owner_q;
    hmastlock_d = bus.HLOCK[owner_q];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_PARK;
      owner_q     <= DEF_IDX;
      grant_q     <= MASTER_COUNT'(1) << DEF_IDX;
      rr_ptr_q    <= DEF_IDX;
      hold_cnt_q  <= '0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;
  assign dbg_state_o    = (state_q == ST_OWN);
  assign dbg_hold_cnt_o = hold_cnt_q;

endmodule
